// File: rtl/vending_machine_ctrl.sv
// rtl/vending_machine_ctrl.sv - coin-credit vending FSM with a registered one-cycle dispense pulse
module vending_machine_ctrl #(
  parameter int PRICE = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in,
  output logic       out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S5   = 2'd1,
    S10  = 2'd2,
    S15  = 2'd3
  } state_t;

  localparam logic [6:0] PRICE_W = 7'(PRICE);

  state_t     state;
  state_t     state_next;
  logic       dispense;
  logic [6:0] credit;
  logic [6:0] coin;
  logic [6:0] total;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      out   <= 1'b0;
    end else begin
      state <= state_next;
      out   <= dispense;
    end
  end

  // Illegal coin codes decode to zero so they behave exactly like "no coin".
  always_comb begin
    credit = 7'd0;
    case (state)
      IDLE: credit = 7'd0;
      S5:   credit = 7'd5;
      S10:  credit = 7'd10;
      S15:  credit = 7'd15;
      default: credit = 7'd0;
    endcase
    coin = 7'd0;
    case (in)
      6'd5, 6'd10, 6'd20: coin = {1'b0, in};
      default:            coin = 7'd0;
    endcase
    total = credit + coin;
  end

  always_comb begin
    state_next = state;
    if (coin != 7'd0) begin
      if (total >= PRICE_W) begin
        state_next = IDLE;
      end else begin
        case (total)
          7'd5:    state_next = S5;
          7'd10:   state_next = S10;
          7'd15:   state_next = S15;
          default: state_next = state;
        endcase
      end
    end
  end

  // Overpayment is forfeited: any completing coin yields exactly one dispense.
  always_comb begin
    dispense = 1'b0;
    if ((coin != 7'd0) && (total >= PRICE_W)) begin
      dispense = 1'b1;
    end
  end

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// tb/tb_vending_machine_ctrl.sv - table-driven self-checking bench for vending_machine_ctrl
module tb_vending_machine_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] in;
  logic       out;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       rst;
    logic [5:0] coin;
    logic       exp_out;
    string      name;
  } vec_t;

  vec_t vecs[$];

  vending_machine_ctrl #(.PRICE(20)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] c, input logic e, input string n);
    vec_t v;
    v.rst = r;
    v.coin = c;
    v.exp_out = e;
    v.name = n;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; out is checked just before the next falling edge.
  task automatic step(input logic r, input logic [5:0] c, input logic e, input string n);
    @(negedge clk);
    rst = r;
    in  = c;
    @(posedge clk);
    #1;
    tests_run++;
    if (out !== e) begin
      tests_failed++;
      $display("FAIL %s: out=%b expected=%b", n, out, e);
    end
  endtask

  initial begin
    rst = 1'b0;
    in  = 6'd0;

    add(0, 6'd0,  0, "reset_state");
    add(0, 6'd0,  0, "reset_hold");
    // coins 5,10,5 then 20: back-to-back dispense
    add(1, 6'd5,  0, "seq_a_5");
    add(1, 6'd10, 0, "seq_a_10");
    add(1, 6'd5,  1, "seq_a_complete");
    add(1, 6'd20, 1, "seq_a_back_to_back");
    add(1, 6'd0,  0, "seq_a_drop");
    // idle gaps keep credit
    add(1, 6'd5,  0, "gap_5");
    add(1, 6'd0,  0, "gap_0a");
    add(1, 6'd0,  0, "gap_0b");
    add(1, 6'd5,  0, "gap_5b");
    add(1, 6'd0,  0, "gap_0c");
    add(1, 6'd10, 1, "gap_complete");
    add(1, 6'd0,  0, "gap_drop");
    // S15 + 10 forfeits 5, next 5 lands in S5
    add(1, 6'd5,  0, "ovp_a_5");
    add(1, 6'd10, 0, "ovp_a_s15");
    add(1, 6'd10, 1, "ovp_a_dispense");
    add(1, 6'd5,  0, "ovp_a_s5");
    add(1, 6'd10, 0, "ovp_a_s15_again");
    add(1, 6'd5,  1, "ovp_a_no_carry");
    // S5 + 20 forfeits 5
    add(1, 6'd5,  0, "ovp_b_5");
    add(1, 6'd20, 1, "ovp_b_dispense");
    add(1, 6'd10, 0, "ovp_b_s10");
    add(1, 6'd5,  0, "ovp_b_s15");
    add(1, 6'd5,  1, "ovp_b_no_carry");
    // invalid codes ignored in S10
    add(1, 6'd10, 0, "inv_s10");
    add(1, 6'd7,  0, "inv_7");
    add(1, 6'd63, 0, "inv_63");
    add(1, 6'd15, 0, "inv_15");
    add(1, 6'd1,  0, "inv_1");
    add(1, 6'd10, 1, "inv_complete");
    // reset mid-transaction beats a coin on the same edge
    add(1, 6'd5,  0, "rst_mid_5");
    add(1, 6'd10, 0, "rst_mid_s15");
    add(0, 6'd5,  0, "rst_mid_reset");
    add(1, 6'd5,  0, "rst_mid_s5");
    add(1, 6'd10, 0, "rst_mid_s15b");
    add(1, 6'd5,  1, "rst_mid_complete");
    // reset with completing coin in S15: no dispense
    add(1, 6'd10, 0, "rst_pri_10");
    add(1, 6'd5,  0, "rst_pri_s15");
    add(0, 6'd20, 0, "rst_pri_coin_lost");
    add(1, 6'd0,  0, "rst_pri_idle");
    // hold 10 for four cycles
    add(1, 6'd10, 0, "hold10_1");
    add(1, 6'd10, 1, "hold10_2");
    add(1, 6'd10, 0, "hold10_3");
    add(1, 6'd10, 1, "hold10_4");
    add(1, 6'd0,  0, "hold10_drop");
    // S10 + 20 and S15 + 20
    add(1, 6'd10, 0, "s10_20_a");
    add(1, 6'd20, 1, "s10_20_b");
    add(1, 6'd5,  0, "s15_20_a");
    add(1, 6'd10, 0, "s15_20_b");
    add(1, 6'd20, 1, "s15_20_c");
    add(1, 6'd0,  0, "s15_20_drop");

    tests_run    = 0;
    tests_failed = 0;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].coin, vecs[i].exp_out, vecs[i].name);
    end

    // Held 20 dispenses every cycle, then stops as soon as the coin is removed.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 6'd20, 1'b1, "hold20");
    end
    step(1'b1, 6'd0, 1'b0, "hold20_release");
    step(1'b1, 6'd0, 1'b0, "hold20_quiet");

    // Five 5-coins: pulse on the fourth, fifth leaves S5 (confirmed by 5,5,5 -> pulse on third).
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 6'd5, (k == 4) ? 1'b1 : 1'b0, "five_fives");
    end
    step(1'b1, 6'd5, 1'b0, "five_fives_s10");
    step(1'b1, 6'd5, 1'b0, "five_fives_s15");
    step(1'b1, 6'd5, 1'b1, "five_fives_complete");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
